// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared constants, scan state and display-word types for the seven-segment scanner
package sevenseg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int NIBBLE_W   = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 8'hFF;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    typedef struct packed {
        logic [NUM_DIGITS*NIBBLE_W-1:0] word;
        logic [NUM_DIGITS-1:0]          en;
        logic [NUM_DIGITS-1:0]          dp;
    } disp_t;

    // Active-low one-cold anode pattern for a digit index
    function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [IDX_W-1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/sevenseg_slot_timer.sv
// sevenseg_slot_timer: slot counter, BLANK/DRIVE decode, digit index and frame_done pulse
// SEVENSEG_SCAN_DIM_EN adds a per-DRIVE-phase 4-bit PWM counter.
// The *_nxt_o outputs describe the cycle that follows the next edge, so the
// parent can register its outputs and keep them aligned with this timer.
module sevenseg_slot_timer
    import sevenseg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] idx_nxt_o,
    output scan_state_e      state_nxt_o,
`ifdef SEVENSEG_SCAN_DIM_EN
    output logic [3:0]       pwm_nxt_o,
`endif
    output logic             frame_done_o
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             frame_done_q, frame_done_d;
    logic             wrap;

    // Next slot position, phase and end-of-frame decode
    always_comb begin
        wrap         = cnt_q == CW'(DIGIT_CYCLES - 1);
        cnt_d        = wrap ? '0 : cnt_q + 1'b1;
        idx_d        = wrap ? idx_q + 1'b1 : idx_q;
        frame_done_d = (cnt_d == CW'(DIGIT_CYCLES - 1)) && (idx_d == IDX_W'(NUM_DIGITS - 1));
        state_nxt_o  = (cnt_d < CW'(BLANK_CYCLES)) ? BLANK : DRIVE;
        idx_nxt_o    = idx_d;
    end

    // Slot counter, digit index and frame pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_done_o = frame_done_q;

`ifdef SEVENSEG_SCAN_DIM_EN
    logic [3:0] pwm_q, pwm_d;

    // PWM phase restarts on the first DRIVE cycle of every slot
    always_comb begin
        pwm_d     = (cnt_d == CW'(BLANK_CYCLES)) ? 4'd0 : pwm_q + 4'd1;
        pwm_nxt_o = pwm_d;
    end

    // PWM counter register
    always_ff @(posedge clk) begin
        if (rst) pwm_q <= 4'd0;
        else     pwm_q <= pwm_d;
    end
`endif

endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: 8-digit time-multiplexed scan controller with frame-synchronous display update
// SEVENSEG_SCAN_DIM_EN adds the brightness input and PWM gating of anodes and dp.
// Loads go to a staging copy; the shadow copy that drives the display only
// changes on the frame_done cycle, so a frame never mixes old and new data.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] disp_word,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp_in,
    input  logic        load,
`ifdef SEVENSEG_SCAN_DIM_EN
    input  logic [3:0]  brightness,
`endif
    output logic [3:0]  num,
    output logic [7:0]  an,
    output logic        dp_n,
    output logic        frame_done
);

    logic [IDX_W-1:0] idx_nxt;
    scan_state_e      state_nxt;
    logic             gate;

    disp_t            in_w, staging_q, staging_d, shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic [3:0]       num_q, num_d;
    logic [7:0]       an_q, an_d;
    logic             dp_n_q, dp_n_d;
    logic             lit;

    sevenseg_slot_timer #(
        .DIGIT_CYCLES(DIGIT_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .idx_nxt_o   (idx_nxt),
        .state_nxt_o (state_nxt),
`ifdef SEVENSEG_SCAN_DIM_EN
        .pwm_nxt_o   (pwm_nxt),
`endif
        .frame_done_o(frame_done)
    );

`ifdef SEVENSEG_SCAN_DIM_EN
    logic [3:0] pwm_nxt;
    assign gate = pwm_nxt < brightness;
`else
    assign gate = 1'b1;
`endif

    // Staging/shadow hand-off and registered output decode for the next cycle
    always_comb begin
        in_w      = '{word: disp_word, en: digit_en, dp: dp_in};
        staging_d = load ? in_w : staging_q;
        shadow_d  = frame_done ? (load ? in_w : (pending_q ? staging_q : shadow_q)) : shadow_q;
        pending_d = frame_done ? 1'b0 : (pending_q | load);
        lit       = (state_nxt == DRIVE) && shadow_d.en[idx_nxt] && gate;
        num_d     = shadow_d.word[idx_nxt*NIBBLE_W +: NIBBLE_W];
        an_d      = lit ? anode_sel(idx_nxt) : ANODES_OFF;
        dp_n_d    = ~(lit & shadow_d.dp[idx_nxt]);
    end

    // Display data and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            staging_q <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            num_q     <= 4'd0;
            an_q      <= ANODES_OFF;
            dp_n_q    <= 1'b1;
        end else begin
            staging_q <= staging_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            num_q     <= num_d;
            an_q      <= an_d;
            dp_n_q    <= dp_n_d;
        end
    end

    assign num  = num_q;
    assign an   = an_q;
    assign dp_n = dp_n_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: randomized self-checking bench against a cycle-position reference model
module tb_sevenseg_scan;

    localparam int DC = 8;
    localparam int BC = 2;
    localparam int FR = 8 * DC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] disp_word = '0;
    logic [7:0]  digit_en = '0;
    logic [7:0]  dp_in = '0;
    logic        load = 1'b0;
    logic [3:0]  num;
    logic [7:0]  an;
    logic        dp_n;
    logic        frame_done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Reference model: k = cycles since reset release; m_* = displayed frame data
    int          k = 0;
    logic [31:0] m_w = '0, s_w = '0;
    logic [7:0]  m_en = '0, m_dp = '0, s_en = '0, s_dp = '0;
    bit          pend = 0;

    sevenseg_scan #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .clk       (clk),
        .rst       (rst),
        .disp_word (disp_word),
        .digit_en  (digit_en),
        .dp_in     (dp_in),
        .load      (load),
        .num       (num),
        .an        (an),
        .dp_n      (dp_n),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] obs();
        return {an, num, dp_n, frame_done};
    endfunction

    function automatic logic [13:0] model_out();
        int slot, c;
        logic on;
        logic [7:0] a;
        slot = (k / DC) % 8;
        c    = k % DC;
        on   = (c >= BC) && m_en[slot];
        a    = on ? ~(8'h01 << slot) : 8'hFF;
        return {a, m_w[slot*4 +: 4], ~(on & m_dp[slot]), (k % FR) == FR - 1};
    endfunction

    task automatic tick(input logic l, input logic [31:0] w, input logic [7:0] e, input logic [7:0] d, input logic r);
        bit fd;
        load = l; disp_word = w; digit_en = e; dp_in = d; rst = r;
        @(posedge clk);
        if (r) begin
            k = 0; m_w = '0; m_en = '0; m_dp = '0; s_w = '0; s_en = '0; s_dp = '0; pend = 0;
        end else begin
            fd = (k % FR) == FR - 1;
            if (fd) begin
                if (l) begin m_w = w; m_en = e; m_dp = d; end
                else if (pend) begin m_w = s_w; m_en = s_en; m_dp = s_dp; end
                pend = 0;
            end else if (l) pend = 1;
            if (l) begin s_w = w; s_en = e; s_dp = d; end
            k++;
        end
        cyc++;
        @(negedge clk);
        load = 1'b0; rst = 1'b0;
    endtask

    task automatic idle_to(input int pos);
        for (int i = 0; i < FR && (k % FR) != pos; i++) tick(0, '0, '0, '0, 0);
    endtask

    task automatic test_reset();
        repeat (3) tick(0, 32'hFFFF_FFFF, 8'hFF, 8'hFF, 1);
        tests++;
        if (obs() !== {8'hFF, 4'h0, 1'b1, 1'b0}) begin
            fails++; $display("FAIL reset_state got %h exp %h", obs(), {8'hFF, 4'h0, 1'b1, 1'b0});
        end
        repeat (FR) begin
            tests++;
            if (obs() !== model_out()) begin fails++; $display("FAIL reset_idle k=%0d got %h exp %h", k, obs(), model_out()); end
            tick(0, '0, '0, '0, 0);
        end
    endtask

    task automatic test_basic();
        int last = -1;
        tick(1, 32'h7654_3210, 8'hFF, 8'h00, 0);
        repeat (3 * FR) begin
            tests++;
            if (obs() !== model_out()) begin fails++; $display("FAIL basic k=%0d got %h exp %h", k, obs(), model_out()); end
            if (m_w == 32'h7654_3210 && (k % FR) == 3 * DC + 4) begin
                tests++;
                if (an !== 8'hF7 || num !== 4'h3) begin fails++; $display("FAIL basic_slot3 an=%h num=%h exp F7 3", an, num); end
            end
            if (frame_done === 1'b1) begin
                if (last >= 0) begin
                    tests++;
                    if (cyc - last != FR) begin fails++; $display("FAIL fd_period got %0d exp %0d", cyc - last, FR); end
                end
                last = cyc;
            end
            tick(0, '0, '0, '0, 0);
        end
    endtask

    task automatic test_enable();
        bit bad = 0;
        tick(1, $urandom, 8'b1010_1010, 8'h00, 0);
        repeat (2 * FR) begin
            tests++;
            if (obs() !== model_out()) begin fails++; $display("FAIL enable k=%0d got %h exp %h", k, obs(), model_out()); end
            if (m_en == 8'hAA && ((k / DC) % 2) == 0 && an !== 8'hFF) bad = 1;
            tick(0, '0, '0, '0, 0);
        end
        tests++;
        if (bad) begin fails++; $display("FAIL enable_even_dark got lit exp 8'hFF"); end
    endtask

    task automatic test_dp();
        bit bad = 0;
        tick(1, $urandom, 8'hFF, 8'h04, 0);
        repeat (2 * FR) begin
            tests++;
            if (obs() !== model_out()) begin fails++; $display("FAIL dp k=%0d got %h exp %h", k, obs(), model_out()); end
            if (m_dp == 8'h04 && dp_n !== !(((k / DC) % 8) == 2 && (k % DC) >= BC)) bad = 1;
            tick(0, '0, '0, '0, 0);
        end
        tests++;
        if (bad) begin fails++; $display("FAIL dp_slot2 got wrong dp_n exp low only in slot 2 DRIVE"); end
    endtask

    task automatic test_double_load();
        bit bad = 0;
        idle_to(20);
        tick(1, 32'hAAAA_AAAA, 8'hFF, 8'h00, 0);
        repeat (5) tick(0, '0, '0, '0, 0);
        tick(1, 32'hBBBB_BBBB, 8'hFF, 8'h00, 0);
        repeat (2 * FR) begin
            tests++;
            if (obs() !== model_out()) begin fails++; $display("FAIL double k=%0d got %h exp %h", k, obs(), model_out()); end
            if (m_w == 32'hBBBB_BBBB && num !== 4'hB) bad = 1;
            tick(0, '0, '0, '0, 0);
        end
        tests++;
        if (bad || m_w !== 32'hBBBB_BBBB) begin fails++; $display("FAIL double_last_wins got %h exp BBBBBBBB", m_w); end
    endtask

    task automatic test_coincident();
        bit bad = 0;
        idle_to(FR - 1);
        tests++;
        if (frame_done !== 1'b1) begin fails++; $display("FAIL coincident_fd got %b exp 1", frame_done); end
        tick(1, 32'hCCCC_CCCC, 8'hFF, 8'h00, 0);
        repeat (FR) begin
            tests++;
            if (obs() !== model_out()) begin fails++; $display("FAIL coincident k=%0d got %h exp %h", k, obs(), model_out()); end
            if (num !== 4'hC) bad = 1;
            tick(0, '0, '0, '0, 0);
        end
        tests++;
        if (bad) begin fails++; $display("FAIL coincident_next_frame got other nibble exp C"); end
    endtask

    task automatic test_mid_reset();
        bit bad = 0;
        idle_to(5 * DC + 3);
        tick(1, 32'hDDDD_DDDD, 8'hFF, 8'hFF, 0);
        tick(0, '0, '0, '0, 1);
        tests++;
        if (obs() !== {8'hFF, 4'h0, 1'b1, 1'b0}) begin
            fails++; $display("FAIL mid_reset got %h exp %h", obs(), {8'hFF, 4'h0, 1'b1, 1'b0});
        end
        repeat (2 * FR) begin
            tests++;
            if (obs() !== model_out()) begin fails++; $display("FAIL mid_reset_run k=%0d got %h exp %h", k, obs(), model_out()); end
            if (num !== 4'h0 || an !== 8'hFF) bad = 1;
            tick(0, '0, '0, '0, 0);
        end
        tests++;
        if (bad) begin fails++; $display("FAIL mid_reset_pending_dropped got old data exp blank"); end
    endtask

    task automatic test_random();
        repeat (1500) begin
            tests++;
            if (obs() !== model_out()) begin fails++; $display("FAIL random k=%0d got %h exp %h", k, obs(), model_out()); end
            tick($urandom_range(0, 15) == 0, $urandom, 8'($urandom), 8'($urandom), $urandom_range(0, 399) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_enable();
        test_dp();
        test_double_load();
        test_coincident();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
